// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage constants and FSM state encoding
package fetch_unit_pkg;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] DEF_BOOT_ADDR = 32'h0000_1000;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_unit_pc.sv
// fetch_pc: program counter with boot reset, +4 increment and word-aligned redirect load
// Ports: clk, reset (async, active-high), inc, load, target in; pc, pc_plus, tgt out
module fetch_pc
    import fetch_unit_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] BOOT_ADDR = DEF_BOOT_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 load,
    input  logic [WORD_SIZE-1:0] target,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pc_plus,
    output logic [WORD_SIZE-1:0] tgt
);
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    assign tgt     = target & ~WORD_SIZE'(3);
    assign pc_plus = pc_q + WORD_SIZE'(INSTR_BYTES);
    assign pc      = pc_q;
    always_comb pc_d = load ? tgt : inc ? pc_plus : pc_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) pc_q <= BOOT_ADDR;
        else       pc_q <= pc_d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, single-outstanding icache requester, one-entry stall buffer, branch redirect
// Ports: clk, reset (async, active-high), stall, branch_taken/branch_target; icache_req/addr out,
//        icache_ready/data in; rm0_out, instruction_out, active_out (one-cycle delivery pulse).
// Optional: define FETCH_TRACE_EN for delivery/redirect $display tracing.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] BOOT_ADDR = DEF_BOOT_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target,
    output logic                 icache_req,
    output logic [WORD_SIZE-1:0] icache_addr,
    input  logic                 icache_ready,
    input  logic [WORD_SIZE-1:0] icache_data,
    output logic [WORD_SIZE-1:0] rm0_out,
    output logic [WORD_SIZE-1:0] instruction_out,
    output logic                 active_out
);
    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d, rm0_q, rm0_d, instr_q, instr_d;
    logic [WORD_SIZE-1:0] buf_pc_q, buf_pc_d, buf_instr_q, buf_instr_d;
    logic                 active_q, active_d;
    logic                 pc_inc, pc_load;
    logic [WORD_SIZE-1:0] pc, pc_plus, tgt;

    fetch_pc #(.WORD_SIZE(WORD_SIZE), .BOOT_ADDR(BOOT_ADDR)) u_pc (
        .clk(clk), .reset(reset), .inc(pc_inc), .load(pc_load),
        .target(branch_target), .pc(pc), .pc_plus(pc_plus), .tgt(tgt)
    );

    // Request is combinational from state so reset withdraws it immediately.
    assign icache_req      = (state_q == REQ) || (state_q == DRAIN);
    assign icache_addr     = addr_q;
    assign rm0_out         = rm0_q;
    assign instruction_out = instr_q;
    assign active_out      = active_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rm0_d       = rm0_q;
        instr_d     = instr_q;
        active_d    = 1'b0;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                addr_d  = pc;
            end
            REQ: begin
                if (branch_taken) begin
                    // Returning data is wrong-path; an unreturned request must drain first.
                    pc_load = 1'b1;
                    state_d = icache_ready ? REQ : DRAIN;
                    addr_d  = icache_ready ? tgt : addr_q;
                end else if (icache_ready && !stall) begin
                    rm0_d    = addr_q;
                    instr_d  = icache_data;
                    active_d = 1'b1;
                    pc_inc   = 1'b1;
                    addr_d   = pc_plus;
                end else if (icache_ready) begin
                    buf_pc_d    = addr_q;
                    buf_instr_d = icache_data;
                    pc_inc      = 1'b1;
                    state_d     = HOLD;
                end
            end
            DRAIN: begin
                pc_load = branch_taken;
                if (icache_ready) begin
                    // A redirect coinciding with the drain completion wins over the older pc.
                    addr_d  = branch_taken ? tgt : pc;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    addr_d  = tgt;
                    state_d = REQ;
                end else if (!stall) begin
                    rm0_d    = buf_pc_q;
                    instr_d  = buf_instr_q;
                    active_d = 1'b1;
                    addr_d   = pc;
                    state_d  = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= BOOT_ADDR;
            rm0_q       <= '0;
            instr_q     <= '0;
            active_q    <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rm0_q       <= rm0_d;
            instr_q     <= instr_d;
            active_q    <= active_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (!reset && active_d) $display("FetchUnit: pc = %h, instruction = %h", rm0_d, instr_d);
        if (!reset && pc_load) $display("FetchUnit: redirect %h", tgt);
    end
`else
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit deliveries, stalls, redirects and reset
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready = 1'b0;
    logic [31:0] icache_data = '0;
    logic [31:0] rm0_out, instruction_out;
    logic        active_out;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t sb[$];
    int total = 0;
    int bad = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_ready(icache_ready), .icache_data(icache_data), .rm0_out(rm0_out),
        .instruction_out(instruction_out), .active_out(active_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (active_out) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: rm0=%h ins=%h, required no pulse", rm0_out, instruction_out);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (rm0_out !== e.pc || instruction_out !== e.ins) begin
                    bad++;
                    $display("FAIL delivery: rm0=%h ins=%h, required rm0=%h ins=%h",
                             rm0_out, instruction_out, e.pc, e.ins);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic expect_addr(input string nm, input logic req, input logic [31:0] a);
        total++;
        if (icache_req !== req || icache_addr !== a) begin
            bad++;
            $display("FAIL %s: req=%b addr=%h, required req=%b addr=%h", nm, icache_req, icache_addr, req, a);
        end
    endtask

    task automatic expect_active(input string nm, input logic v);
        total++;
        if (active_out !== v) begin
            bad++;
            $display("FAIL %s: active=%b, required %b", nm, active_out, v);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] d);
        ent_t e;
        e.pc = p;
        e.ins = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        icache_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++;
        if (icache_req !== 1'b0 || icache_addr !== 32'h1000 || rm0_out !== 32'h0 ||
            instruction_out !== 32'h0 || active_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b addr=%h rm0=%h ins=%h act=%b, required 0 1000 0 0 0",
                     icache_req, icache_addr, rm0_out, instruction_out, active_out);
        end
        do_reset();
        expect_addr("first_req", 1'b1, 32'h1000);
    endtask

    task automatic test_stream();
        logic [31:0] p;
        p = 32'h1000;
        for (int k = 0; k < 5; k++) begin
            expect_addr("stream_addr", 1'b1, p);
            if (k > 0) expect_active("stream_active", 1'b1);
            icache_ready = 1'b1;
            icache_data = p ^ 32'h5A5A_0000;
            push(p, p ^ 32'h5A5A_0000);
            p = p + 32'd4;
            cyc();
        end
        icache_ready = 1'b0;
        expect_addr("stream_end_addr", 1'b1, p);
        cyc();
        expect_active("stream_quiet", 1'b0);
    endtask

    task automatic test_latency();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            expect_addr("lat_hold", 1'b1, 32'h1000);
            expect_active("lat_nopulse", 1'b0);
            cyc();
        end
        icache_ready = 1'b1;
        icache_data = 32'hDEAD_BEEF;
        push(32'h1000, 32'hDEAD_BEEF);
        cyc();
        icache_ready = 1'b0;
        expect_addr("lat_next", 1'b1, 32'h1004);
        cyc();
        expect_active("lat_single", 1'b0);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        icache_ready = 1'b1;
        icache_data = 32'h00A0_0093;
        cyc();
        icache_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            expect_addr("hold_noreq", 1'b0, 32'h1004);
            expect_active("hold_nopulse", 1'b0);
            cyc();
        end
        stall = 1'b0;
        push(32'h1004, 32'h00A0_0093);
        cyc();
        expect_active("hold_release", 1'b1);
        expect_addr("hold_next_req", 1'b1, 32'h1008);
    endtask

    task automatic test_branch_drain();
        branch_taken = 1'b1;
        branch_target = 32'h2003;
        cyc();
        branch_taken = 1'b0;
        expect_addr("drain_old_addr", 1'b1, 32'h1008);
        cyc();
        icache_ready = 1'b1;
        icache_data = 32'hBAD0_0001;
        cyc();
        icache_ready = 1'b0;
        expect_addr("drain_redirect", 1'b1, 32'h2000);
        expect_active("drain_dropped", 1'b0);
        branch_taken = 1'b1;
        branch_target = 32'h2101;
        icache_ready = 1'b1;
        icache_data = 32'hBAD0_0002;
        cyc();
        branch_taken = 1'b0;
        icache_ready = 1'b0;
        expect_addr("req_branch_ready", 1'b1, 32'h2100);
        expect_active("req_branch_dropped", 1'b0);
    endtask

    task automatic test_hold_branch();
        stall = 1'b1;
        icache_ready = 1'b1;
        icache_data = 32'hBAD0_0003;
        cyc();
        icache_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h3000;
        cyc();
        branch_taken = 1'b0;
        expect_addr("hold_branch_req", 1'b1, 32'h3000);
        expect_active("hold_branch_dropped", 1'b0);
        stall = 1'b0;
        icache_ready = 1'b1;
        icache_data = 32'h1234_5678;
        push(32'h3000, 32'h1234_5678);
        cyc();
        icache_ready = 1'b0;
        expect_addr("after_hold_branch", 1'b1, 32'h3004);
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        cyc();
        branch_taken = 1'b0;
        icache_ready = 1'b1;
        cyc();
        expect_addr("wrap_target", 1'b1, 32'hFFFF_FFFC);
        icache_data = 32'hCAFE_F00D;
        push(32'hFFFF_FFFC, 32'hCAFE_F00D);
        cyc();
        icache_ready = 1'b0;
        expect_addr("wrap_zero", 1'b1, 32'h0000_0000);
    endtask

    task automatic test_reset_mid();
        cyc();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (icache_req !== 1'b0 || icache_addr !== 32'h1000 || rm0_out !== 32'h0 ||
            instruction_out !== 32'h0 || active_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: req=%b addr=%h rm0=%h ins=%h act=%b, required 0 1000 0 0 0",
                     icache_req, icache_addr, rm0_out, instruction_out, active_out);
        end
        do_reset();
        expect_addr("restart", 1'b1, 32'h1000);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_stall();
        test_branch_drain();
        test_hold_branch();
        test_reset_mid();
        cyc();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: pending=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
